// File: rtl/alu_mc_if.sv
// ============================================================================
//  Module      : alu_mc_if
//  Description : Request/response bundle for the multi-cycle ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_mc_if #(
    parameter int BIT_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           op;
    logic [BIT_WIDTH-1:0] a;
    logic [BIT_WIDTH-1:0] b;
    logic [BIT_WIDTH-1:0] pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] r;
    logic                 flag_z;
    logic                 flag_c;

    modport master (
        output in_valid, op, a, b, pc, out_ready,
        input  in_ready, out_valid, r, flag_z, flag_c
    );

    modport slave (
        input  in_valid, op, a, b, pc, out_ready,
        output in_ready, out_valid, r, flag_z, flag_c
    );
endinterface

`default_nettype wire

// File: rtl/alu_mc.sv
// ============================================================================
//  Module      : alu_mc
//  Description : ALU with single-cycle logic/arithmetic ops and iterative
//                shift-add multiply / restoring unsigned divide.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mc #(
    parameter int BIT_WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int                   c_CNT_W    = (BIT_WIDTH > 2) ? $clog2(BIT_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(BIT_WIDTH - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [BIT_WIDTH-1:0] c_ONE      = BIT_WIDTH'(1);

    localparam logic [3:0] c_OP_CP   = 4'd0;
    localparam logic [3:0] c_OP_ADD  = 4'd1;
    localparam logic [3:0] c_OP_SUB  = 4'd2;
    localparam logic [3:0] c_OP_NOT  = 4'd3;
    localparam logic [3:0] c_OP_AND  = 4'd4;
    localparam logic [3:0] c_OP_OR   = 4'd5;
    localparam logic [3:0] c_OP_XOR  = 4'd6;
    localparam logic [3:0] c_OP_RSH  = 4'd7;
    localparam logic [3:0] c_OP_LSH  = 4'd8;
    localparam logic [3:0] c_OP_CMPG = 4'd9;
    localparam logic [3:0] c_OP_CMPE = 4'd10;
    localparam logic [3:0] c_OP_CMPL = 4'd11;
    localparam logic [3:0] c_OP_OUTT = 4'd12;
    localparam logic [3:0] c_OP_OUTF = 4'd13;
    localparam logic [3:0] c_OP_MUL  = 4'd14;
    localparam logic [3:0] c_OP_DIVU = 4'd15;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_is_div;
    logic [BIT_WIDTH-1:0] r_a;      // multiplicand (MUL) or dividend/quotient shifter (DIVU)
    logic [BIT_WIDTH-1:0] r_b;      // multiplier shifter (MUL) or divisor (DIVU)
    logic [BIT_WIDTH-1:0] r_acc;    // product accumulator (MUL) or partial remainder (DIVU)
    logic [BIT_WIDTH-1:0] r_res;
    logic                 r_z;
    logic                 r_c;

    logic                 w_accept;
    logic                 w_multicycle;
    logic                 w_last;
    logic [BIT_WIDTH:0]   w_add;
    logic [BIT_WIDTH:0]   w_sub;
    logic [BIT_WIDTH-1:0] w_pc_inc;
    logic [BIT_WIDTH-1:0] w_res;
    logic                 w_c;
    logic [BIT_WIDTH:0]   w_rem_sh;
    logic [BIT_WIDTH:0]   w_diff;
    logic                 w_ge;
    logic [BIT_WIDTH-1:0] w_rem_nxt;
    logic [BIT_WIDTH-1:0] w_quo_nxt;
    logic [BIT_WIDTH-1:0] w_prod_nxt;
    logic [BIT_WIDTH-1:0] w_mc_res;

    assign w_accept     = bus.in_valid && (r_state == S_IDLE);
    assign w_multicycle = (bus.op == c_OP_MUL) || (bus.op == c_OP_DIVU);
    assign w_last       = (r_cnt == c_CNT_LAST);

    assign w_add    = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_sub    = {1'b0, bus.a} - {1'b0, bus.b};
    assign w_pc_inc = bus.pc + c_ONE;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        case (bus.op)
            c_OP_CP:   w_res = bus.a;
            c_OP_ADD:  begin w_res = w_add[BIT_WIDTH-1:0]; w_c = w_add[BIT_WIDTH]; end
            c_OP_SUB:  begin w_res = w_sub[BIT_WIDTH-1:0]; w_c = w_sub[BIT_WIDTH]; end
            c_OP_NOT:  w_res = ~bus.a;
            c_OP_AND:  w_res = bus.a & bus.b;
            c_OP_OR:   w_res = bus.a | bus.b;
            c_OP_XOR:  w_res = bus.a ^ bus.b;
            c_OP_RSH:  w_res = bus.a >> 1;
            c_OP_LSH:  w_res = bus.a << 1;
            c_OP_CMPG: w_res = {BIT_WIDTH{bus.a > bus.b}};
            c_OP_CMPE: w_res = {BIT_WIDTH{bus.a == bus.b}};
            c_OP_CMPL: w_res = {BIT_WIDTH{bus.a < bus.b}};
            c_OP_OUTT: w_res = (&bus.a) ? bus.b : w_pc_inc;
            c_OP_OUTF: w_res = (bus.a == '0) ? bus.b : w_pc_inc;
            default:   w_res = '0;
        endcase
    end

    // Restoring-division step: the trial difference's top bit is the borrow,
    // since the shifted remainder is always below twice the divisor.
    assign w_rem_sh   = {r_acc, r_a[BIT_WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_ge       = ~w_diff[BIT_WIDTH];
    assign w_rem_nxt  = w_ge ? w_diff[BIT_WIDTH-1:0] : w_rem_sh[BIT_WIDTH-1:0];
    assign w_quo_nxt  = {r_a[BIT_WIDTH-2:0], w_ge};
    assign w_prod_nxt = r_b[0] ? (r_acc + r_a) : r_acc;
    assign w_mc_res   = r_is_div ? w_quo_nxt : w_prod_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_state_nxt = w_multicycle ? S_CALC : S_DONE;
            S_CALC:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_res    <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
        end else if (w_accept) begin
            if (w_multicycle) begin
                r_cnt    <= '0;
                r_is_div <= bus.op[0];
                r_a      <= bus.a;
                r_b      <= bus.b;
                r_acc    <= '0;
            end else begin
                r_res <= w_res;
                r_z   <= (w_res == '0);
                r_c   <= w_c;
            end
        end else if (r_state == S_CALC) begin
            if (r_is_div) begin
                r_acc <= w_rem_nxt;
                r_a   <= w_quo_nxt;
            end else begin
                r_acc <= w_prod_nxt;
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
            end
            if (w_last) begin
                r_cnt <= '0;
                r_res <= w_mc_res;
                r_z   <= (w_mc_res == '0);
                r_c   <= 1'b0;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.r         = r_res;
    assign bus.flag_z    = r_z;
    assign bus.flag_c    = r_c;

endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ============================================================================
//  Module      : tb_alu_mc
//  Description : Scoreboard bench for alu_mc at BIT_WIDTH = 8.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mc;
    localparam int W = 8;

    localparam logic [3:0] c_CP = 4'd0, c_ADD = 4'd1, c_SUB = 4'd2, c_NOT = 4'd3;
    localparam logic [3:0] c_AND = 4'd4, c_OR = 4'd5, c_XOR = 4'd6, c_RSH = 4'd7;
    localparam logic [3:0] c_LSH = 4'd8, c_CMPG = 4'd9, c_CMPE = 4'd10, c_CMPL = 4'd11;
    localparam logic [3:0] c_OUTT = 4'd12, c_OUTF = 4'd13, c_MUL = 4'd14, c_DIVU = 4'd15;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         c;
        int           lat;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur;
    bit   prev_valid = 1'b0;

    alu_mc_if #(.BIT_WIDTH(W)) bus ();

    alu_mc #(.BIT_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops on the first valid cycle, then requires the output held.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result actual=%0h expected=none", bus.r);
                    end else begin
                        cur = sb.pop_front();
                        chk("result_r", bus.r, cur.r);
                        chk("result_z", bus.flag_z, cur.z);
                        chk("result_c", bus.flag_c, cur.c);
                        chk("latency", cyc - cur.acc + 1, cur.lat);
                    end
                end else begin
                    chk("held_r", bus.r, cur.r);
                    chk("held_flags", {bus.flag_z, bus.flag_c}, {cur.z, cur.c});
                end
                chk("busy_in_ready", bus.in_ready, 1'b0);
            end
            prev_valid = bus.out_valid;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] pc, input logic [W-1:0] er, input logic ez,
                         input logic ec, input int elat, input bit push);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        bus.pc = pc;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_ready expected=ready");
        end
        @(posedge clk);
        #1;
        if (push) sb.push_back('{er, ez, ec, elat, cyc});
        // Scramble inputs after accept; the result must use the captured values.
        bus.in_valid = 1'b0;
        bus.op = 4'($urandom);
        bus.a  = W'($urandom);
        bus.b  = W'($urandom);
        bus.pc = W'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            got = bus.out_valid && bus.out_ready;
            n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_valid expected=valid");
        end
        @(posedge clk);
        #1;
        chk("back_to_idle", {bus.out_valid, bus.in_ready}, 2'b01);
    endtask

    task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] pc, input logic [W-1:0] er, input logic ez,
                       input logic ec, input int elat);
        issue(op, a, b, pc, er, ez, ec, elat, 1'b1);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op = '0;
        bus.a  = '0;
        bus.b  = '0;
        bus.pc = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_r", bus.r, 8'h00);
        chk("reset_flags", {bus.flag_z, bus.flag_c}, 2'b00);
        chk("reset_out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", bus.in_ready, 1'b1);

        //   op      a      b      pc     r      z     c    lat
        run(c_ADD,  8'hF0, 8'h20, 8'h00, 8'h10, 1'b0, 1'b1, 1);
        run(c_SUB,  8'h05, 8'h07, 8'h00, 8'hFE, 1'b0, 1'b1, 1);
        run(c_ADD,  8'h80, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1, 1);
        run(c_SUB,  8'h07, 8'h05, 8'h00, 8'h02, 1'b0, 1'b0, 1);
        run(c_CP,   8'h5A, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b0, 1);
        run(c_NOT,  8'h0F, 8'h00, 8'h00, 8'hF0, 1'b0, 1'b0, 1);
        run(c_AND,  8'hF0, 8'h3C, 8'h00, 8'h30, 1'b0, 1'b0, 1);
        run(c_OR,   8'hF0, 8'h3C, 8'h00, 8'hFC, 1'b0, 1'b0, 1);
        run(c_XOR,  8'hF0, 8'h3C, 8'h00, 8'hCC, 1'b0, 1'b0, 1);
        run(c_RSH,  8'h81, 8'h00, 8'h00, 8'h40, 1'b0, 1'b0, 1);
        run(c_LSH,  8'h81, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0, 1);
        run(c_CMPG, 8'h03, 8'h02, 8'h00, 8'hFF, 1'b0, 1'b0, 1);
        run(c_CMPE, 8'h03, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0, 1);
        run(c_CMPE, 8'h44, 8'h44, 8'h00, 8'hFF, 1'b0, 1'b0, 1);
        run(c_OUTT, 8'hFF, 8'h40, 8'h12, 8'h40, 1'b0, 1'b0, 1);
        run(c_OUTT, 8'h01, 8'h40, 8'h12, 8'h13, 1'b0, 1'b0, 1);
        run(c_OUTF, 8'h00, 8'h40, 8'h12, 8'h40, 1'b0, 1'b0, 1);
        run(c_OUTF, 8'h03, 8'h40, 8'hFF, 8'h00, 1'b1, 1'b0, 1);
        run(c_MUL,  8'd13, 8'd11, 8'h00, 8'h8F, 1'b0, 1'b0, 9);
        run(c_MUL,  8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0, 1'b0, 9);
        run(c_MUL,  8'h10, 8'h10, 8'h00, 8'h00, 1'b1, 1'b0, 9);
        run(c_DIVU, 8'd200, 8'd7, 8'h00, 8'h1C, 1'b0, 1'b0, 9);
        run(c_DIVU, 8'd5,  8'd0,  8'h00, 8'hFF, 1'b0, 1'b0, 9);
        run(c_DIVU, 8'd7,  8'd200, 8'h00, 8'h00, 1'b1, 1'b0, 9);
        run(c_DIVU, 8'hFF, 8'h01, 8'h00, 8'hFF, 1'b0, 1'b0, 9);

        // Backpressure: result must hold for five stalled cycles.
        bus.out_ready = 1'b0;
        issue(c_CMPL, 8'h01, 8'h02, 8'h00, 8'hFF, 1'b0, 1'b0, 1, 1'b1);
        repeat (5) @(negedge clk);
        chk("stall_valid", bus.out_valid, 1'b1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release", {bus.out_valid, bus.in_ready}, 2'b01);

        // Reset in the fourth CALC cycle of a MUL discards it.
        issue(c_MUL, 8'd13, 8'd11, 8'h00, 8'h00, 1'b0, 1'b0, 9, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_mul_busy", bus.in_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_r", bus.r, 8'h00);
        chk("abort_flags", {bus.flag_z, bus.flag_c}, 2'b00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run(c_AND, 8'hF0, 8'h3C, 8'h00, 8'h30, 1'b0, 1'b0, 1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter BIT_WIDTH, 32, datapath width (legal range 2..64).
REQ-002 SHALL have ports, one clock, reset asynchronous and active-high:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- op  in  4  operation code
- a  in  BIT_WIDTH  operand A
- b  in  BIT_WIDTH  operand B
- pc  in  BIT_WIDTH  program counter for OUT_T/OUT_F
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- r  out  BIT_WIDTH  result
- flag_z  out  1  r == 0
- flag_c  out  1  carry/borrow of ADD/SUB, else 0

Function
REQ-003 SHALL use op codes: 0 CP, 1 ADD, 2 SUB, 3 NOT, 4 AND, 5 OR, 6 XOR, 7 RSH, 8 LSH, 9 CMP_GREATER, 10 CMP_EQUAL, 11 CMP_LESS, 12 OUT_T, 13 OUT_F, 14 MUL, 15 DIVU.
REQ-004 SHALL use an FSM with states IDLE, CALC, DONE; reset state IDLE.
REQ-005 SHALL drive in_ready = 1 only in IDLE; accept occurs on an edge with in_valid & in_ready; op/a/b/pc SHALL be captured at accept, and later input changes SHALL be ignored.
REQ-006 Ops 0..13 SHALL go IDLE -> DONE at the accept edge, with r/flags registered at that edge (latency 1: out_valid high the cycle after accept).
REQ-007 Ops 14/15 SHALL go IDLE -> CALC, iterate one bit per cycle for exactly BIT_WIDTH cycles, then go CALC -> DONE (out_valid first high BIT_WIDTH+1 cycles after accept).
REQ-008 In DONE: out_valid = 1; r/flags SHALL be held stable; on out_valid & out_ready, DONE -> IDLE; no new accept in the same cycle.
REQ-009 CP: r = A. NOT: ~A. AND/OR/XOR: bitwise. RSH/LSH: logical shift by 1, zero fill.
REQ-010 ADD: r = (A+B) mod 2^BIT_WIDTH, flag_c = carry out of bit BIT_WIDTH-1.
REQ-011 SUB: r = (A-B) mod 2^BIT_WIDTH, flag_c = 1 iff A < B unsigned (borrow).
REQ-012 CMP_*: r = all ones if the unsigned relation (A>B, A==B, A<B) holds, else all zeros.
REQ-013 OUT_T: r = B if A is all ones, else PC+1. OUT_F: r = B if A == 0, else PC+1. PC+1 SHALL wrap mod 2^BIT_WIDTH.
REQ-014 MUL: r = low BIT_WIDTH bits of unsigned A*B, using iterative shift-add.
REQ-015 DIVU: r = unsigned floor(A/B), using restoring division. B == 0 SHALL give r = all ones without error.
REQ-016 flag_z SHALL equal (r == 0) for every op; flag_c SHALL be 0 for all ops except ADD/SUB.
REQ-017 Out-of-range BIT_WIDTH need not be detected; behaviour is undefined.

Reset
REQ-018 rst asserted SHALL asynchronously force state IDLE, r = 0, flag_z = 0, flag_c = 0, out_valid = 0, in_ready = 1 (after release), iteration counter = 0.
REQ-019 rst during CALC or DONE SHALL discard the operation; the first accept after release SHALL behave as from power-up.

Verification (BIT_WIDTH = 8)
REQ-020 ADD a=0xF0 b=0x20 -> r=0x10, flag_c=1, flag_z=0, out_valid one cycle after accept; SUB a=0x05 b=0x07 -> r=0xFE, flag_c=1.
REQ-021 MUL a=13 b=11 -> in_ready low 8 CALC cycles + DONE; out_valid at cycle 9 after accept; r=0x8F; DIVU a=200 b=7 -> r=0x1C; DIVU a=5 b=0 -> r=0xFF.
REQ-022 OUT_T a=0xFF b=0x40 pc=0x12 -> r=0x40; OUT_T a=0x01 pc=0x12 -> r=0x13; OUT_F a=0x00 b=0x40 -> r=0x40; OUT_F a=0x03 pc=0xFF -> r=0x00, flag_z=1.
REQ-023 Backpressure: hold out_ready=0 for 5 cycles after a CMP_LESS (a=1, b=2) -> r=0xFF held, out_valid=1, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-024 Assert rst for 1 cycle mid-MUL (cycle 4 of CALC) -> out_valid=0, r=0 immediately; a subsequent AND a=0xF0 b=0x3C -> r=0x30 with latency 1.
REQ-025 Change a/b/op while in CALC -> result matches the operands captured at accept.
